cache_refill_ctrl: RTL and testbench

//   Write-side counterpart of the tag-compare path. The hit check reads the
//   tag/data arrays through bitwise_comparator; this block handles a miss:
//   - accepts the miss address and requests the line from memory
//   - writes each returned word into the data array
//   - writes the new tag last, which makes the line valid
//   - reports whether a probe address falls inside the line being filled
//

---
 rtl/cache_refill_ctrl_pkg.sv | 36 +++
 rtl/cache_refill_ctrl_if.sv | 50 +++++
 rtl/bitwise_comparator.sv | 12 +
 rtl/cache_refill_ctrl.sv | 119 +++++++++++
 tb/tb_cache_refill_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared cache package: default geometry, refill FSM encoding and address
// field-slice helpers for the default geometry (32-bit byte address,
// 64 sets, 4 words of 32 bits per line).
package cache_refill_ctrl_pkg;

  localparam int AW = 32;
  localparam int IW = 6;
  localparam int WW = 2;
  localparam int TW = AW - IW - WW - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } refill_state_e;

  typedef logic [AW-1:0] addr_t;

  function automatic logic [TW-1:0] tag_of(input addr_t a);
    return a[AW-1:AW-TW];
  endfunction

  function automatic logic [IW-1:0] index_of(input addr_t a);
    return a[IW+WW+1:WW+2];
  endfunction

  function automatic logic [WW-1:0] word_of(input addr_t a);
    return a[WW+1:2];
  endfunction

  function automatic logic [1:0] offset_of(input addr_t a);
    return a[1:0];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Refill controller bus bundle: miss request, memory request/response,
// data/tag array write ports, status and the probe lookup.
//   master : the refill controller side
//   slave  : the requester / memory / array side
interface cache_refill_ctrl_if
  import cache_refill_ctrl_pkg::*;
#(
  parameter int aw = AW,
  parameter int iw = IW,
  parameter int ww = WW
) ();
  localparam int tw = aw - iw - ww - 2;

  logic          miss_valid;
  logic [aw-1:0] miss_addr;
  logic          miss_ready;
  logic          mem_req_valid;
  logic [aw-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          data_we;
  logic [iw-1:0] data_index;
  logic [ww-1:0] data_word;
  logic [31:0]   data_wdata;
  logic          tag_we;
  logic [iw-1:0] tag_index;
  logic [tw-1:0] tag_wdata;
  logic          busy;
  logic          fill_done;
  logic [aw-1:0] probe_addr;
  logic          probe_hit_fill;
  logic          probe_word_rdy;

  modport master (
    input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           probe_addr,
    output miss_ready, mem_req_valid, mem_req_addr, data_we, data_index,
           data_word, data_wdata, tag_we, tag_index, tag_wdata, busy,
           fill_done, probe_hit_fill, probe_word_rdy
  );

  modport slave (
    output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           probe_addr,
    input  miss_ready, mem_req_valid, mem_req_addr, data_we, data_index,
           data_word, data_wdata, tag_we, tag_index, tag_wdata, busy,
           fill_done, probe_hit_fill, probe_word_rdy
  );
endinterface

// File: rtl/bitwise_comparator.sv
// Equality comparator shared with the tag hit path.
//   a, b : operands (w bits)
//   eq   : 1 when a == b
module bitwise_comparator #(
  parameter int w = 8
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic         eq
);
  assign eq = ~|(a ^ b);
endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller. Accepts a miss, requests the line from
// memory, writes the returned words into the data array in order, then
// writes the tag (which marks the line valid). Also tells the lookup path
// whether a probed address falls in the line being filled and whether the
// probed word has already landed.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master side of cache_refill_ctrl_if (miss, mem req/rsp,
//              data/tag writes, busy/fill_done, probe)
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int aw = AW,
  parameter int iw = IW,
  parameter int ww = WW
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_refill_ctrl_if.master  bus
);
  localparam int tw = aw - iw - ww - 2;
  localparam int lw = aw - ww - 2;   // line address width (tag + index)

  refill_state_e state, state_nxt;
  logic [ww-1:0] cnt, cnt_nxt;
  // Only the line address matters after acceptance; word/byte offset of the
  // miss is not needed because the whole line is filled from word 0.
  logic [lw-1:0] line_q, line_nxt;
  logic          line_eq;

  wire [iw-1:0] line_idx = line_q[iw-1:0];
  wire [tw-1:0] line_tag = line_q[lw-1:iw];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      line_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      line_q <= line_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    line_nxt          = line_q;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = '0;
    bus.data_we       = 1'b0;
    bus.data_index    = '0;
    bus.data_word     = '0;
    bus.data_wdata    = '0;
    bus.tag_we        = 1'b0;
    bus.tag_index     = '0;
    bus.tag_wdata     = '0;
    bus.fill_done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.miss_valid) begin
          line_nxt  = bus.miss_addr[aw-1:ww+2];
          state_nxt = REQ;
        end
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {line_q, {(ww+2){1'b0}}};
        if (bus.mem_req_ready) state_nxt = FILL;
      end
      FILL: begin
        if (bus.mem_rsp_valid) begin
          bus.data_we    = 1'b1;
          bus.data_index = line_idx;
          bus.data_word  = cnt;
          bus.data_wdata = bus.mem_rsp_data;
          cnt_nxt        = cnt + 1'b1;   // wraps to 0 after the last word
          if (&cnt) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        bus.tag_we    = 1'b1;
        bus.tag_index = line_idx;
        bus.tag_wdata = line_tag;
        bus.fill_done = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy       = (state != IDLE);
  assign bus.miss_ready = (state == IDLE) && !rst;

  bitwise_comparator #(.w(lw)) u_probe_cmp (
    .a  (bus.probe_addr[aw-1:ww+2]),
    .b  (line_q),
    .eq (line_eq)
  );

  // No word can be in the array before the request is granted, so the probe
  // only reports a match once the fill is actually underway.
  always_comb begin
    bus.probe_hit_fill = 1'b0;
    bus.probe_word_rdy = 1'b0;
    case (state)
      FILL: begin
        bus.probe_hit_fill = line_eq;
        bus.probe_word_rdy = line_eq && (bus.probe_addr[ww+1:2] < cnt);
      end
      COMMIT: begin
        bus.probe_hit_fill = line_eq;
        bus.probe_word_rdy = line_eq;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_refill_ctrl_if bus ();
  cache_refill_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [5:0] idx; logic [1:0] word; logic [31:0] data; } dw_t;
  typedef struct { logic [5:0] idx; logic [21:0] tag; } tw_t;

  dw_t         dq[$];
  tw_t         tq[$];
  logic [31:0] rq[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every observed write / accepted request must match
  // the head of the matching expectation queue.
  always @(negedge clk) begin
    if (bus.data_we === 1'b1) begin
      if (dq.size() == 0) chk("data_we_unexpected", 1, 0);
      else begin
        dw_t e;
        e = dq.pop_front();
        chk("data_wr", {bus.data_index, bus.data_word, bus.data_wdata},
            {e.idx, e.word, e.data});
      end
    end
    if (bus.tag_we === 1'b1) begin
      if (tq.size() == 0) chk("tag_we_unexpected", 1, 0);
      else begin
        tw_t t;
        t = tq.pop_front();
        chk("tag_wr", {bus.tag_index, bus.tag_wdata}, {t.idx, t.tag});
      end
    end
    if (bus.tag_we === 1'b1 || bus.fill_done === 1'b1)
      chk("fill_done_eq_tag_we", bus.fill_done, bus.tag_we);
    if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
      if (rq.size() == 0) chk("mem_req_unexpected", 1, 0);
      else chk("mem_req_addr", bus.mem_req_addr, rq.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input logic [31:0] d);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = d;
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic push_line(input logic [5:0] idx, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] d3);
    dq.push_back('{idx, 2'd0, d0});
    dq.push_back('{idx, 2'd1, d1});
    dq.push_back('{idx, 2'd2, d2});
    dq.push_back('{idx, 2'd3, d3});
  endtask

  initial begin
    bus.miss_valid    = 1'b0;
    bus.miss_addr     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.probe_addr    = '0;

    // 1. reset
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_miss_ready_low", bus.miss_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_miss_ready", bus.miss_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobes", {bus.mem_req_valid, bus.data_we, bus.tag_we, bus.fill_done,
                        bus.probe_hit_fill, bus.probe_word_rdy}, 0);

    // 2 + 4. basic fill with probes after two words
    rq.push_back(32'hac09f570);
    push_line(6'h17, 32'h11, 32'h22, 32'h33, 32'h44);
    tq.push_back('{6'h17, 22'h2b027d});
    bus.miss_valid    = 1'b1;
    bus.miss_addr     = 32'hac09f57d;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.miss_valid = 1'b0;
    chk("t2_req_valid", bus.mem_req_valid, 1);
    cyc();
    rsp(32'h11);
    rsp(32'h22);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h33;
    bus.probe_addr = 32'hac09f574;
    #1;
    chk("t4_hit_574", bus.probe_hit_fill, 1);
    chk("t4_rdy_574", bus.probe_word_rdy, 1);
    bus.probe_addr = 32'hac09f57c;
    #1;
    chk("t4_hit_57c", bus.probe_hit_fill, 1);
    chk("t4_rdy_57c", bus.probe_word_rdy, 0);
    bus.probe_addr = 32'h12345670;
    #1;
    chk("t4_hit_other", bus.probe_hit_fill, 0);
    bus.probe_addr = 32'hac09f57c;
    cyc();
    rsp(32'h44);
    chk("t2_tag_we_after_last", bus.tag_we, 1);
    chk("t2_fill_done", bus.fill_done, 1);
    chk("t2_commit_rdy_57c", bus.probe_word_rdy, 1);
    cyc();
    chk("t2_fill_done_1cyc", bus.fill_done, 0);
    chk("t2_idle_ready", bus.miss_ready, 1);
    chk("t2_idle_hit", bus.probe_hit_fill, 0);

    // 3. request stall and response gaps
    rq.push_back(32'h00001230);
    push_line(6'h23, 32'ha1, 32'hb2, 32'hc3, 32'hd4);
    tq.push_back('{6'h23, 22'h4});
    bus.mem_req_ready = 1'b0;
    bus.miss_valid    = 1'b1;
    bus.miss_addr     = 32'h00001234;
    cyc();
    bus.miss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_req_hold_valid", bus.mem_req_valid, 1);
      chk("t3_req_hold_addr", bus.mem_req_addr, 32'h00001230);
      cyc();
    end
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    rsp(32'ha1);
    cyc();
    chk("t3_gap_no_we", bus.data_we, 0);
    cyc();
    rsp(32'hb2);
    cyc();
    rsp(32'hc3);
    rsp(32'hd4);
    chk("t3_tag_we", bus.tag_we, 1);
    cyc();
    chk("t3_data_q_drained", dq.size(), 0);

    // 5. spurious response in IDLE, then a miss held while busy
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hdead;
    #1;
    chk("t5_idle_rsp_no_we", bus.data_we, 0);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    rq.push_back(32'h80000040);
    push_line(6'h04, 32'h1, 32'h2, 32'h3, 32'h4);
    tq.push_back('{6'h04, 22'h200000});
    bus.miss_valid    = 1'b1;
    bus.miss_addr     = 32'h80000040;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.miss_addr = 32'h000003f8;   // next miss, held by requester
    chk("t5_busy_not_ready_req", bus.miss_ready, 0);
    cyc();
    bus.mem_req_ready = 1'b0;
    rsp(32'h1);
    chk("t5_busy_not_ready_fill", bus.miss_ready, 0);
    rsp(32'h2);
    rsp(32'h3);
    rsp(32'h4);
    chk("t5_commit_not_ready", bus.miss_ready, 0);
    chk("t5_commit_fill_done", bus.fill_done, 1);
    cyc();
    chk("t5_held_accept_ready", bus.miss_ready, 1);

    // 6. second miss accepted here, then reset after two words
    rq.push_back(32'h000003f0);
    dq.push_back('{6'h3f, 2'd0, 32'h55});
    dq.push_back('{6'h3f, 2'd1, 32'h66});
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.miss_valid = 1'b0;
    chk("t6_req_valid", bus.mem_req_valid, 1);
    cyc();
    rsp(32'h55);
    rsp(32'h66);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_idle_after_rst", bus.busy, 0);
    for (int i = 0; i < 2; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h77 + i;
      #1;
      chk("t6_no_we_after_rst", bus.data_we, 0);
      cyc();
    end
    bus.mem_rsp_valid = 1'b0;
    cyc();
    cyc();
    chk("t6_no_tag_we", bus.tag_we, 0);
    chk("t6_ready", bus.miss_ready, 1);

    chk("end_data_q_empty", dq.size(), 0);
    chk("end_tag_q_empty", tq.size(), 0);
    chk("end_req_q_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
